// File: rtl/video_timing_ctrl.sv
// Raster sequencer: pixel/line counters plus registered sync, blanking and
// display-enable outputs that trail the counters by one ce tick.
module video_timing_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk25m,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        display_enable,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic [11:0] HT12     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] VT12     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] HA12     = 12'(H_ACTIVE);
  localparam logic [11:0] VA12     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG12 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END12 = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_BEG12 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END12 = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [11:0] H_LAST12 = HT12 - 12'd1;
  localparam logic [11:0] V_LAST12 = VT12 - 12'd1;
  localparam logic [10:0] H_LAST   = H_LAST12[10:0];
  localparam logic [10:0] V_LAST   = V_LAST12[10:0];
  localparam logic [10:0] H_ACT    = HA12[10:0];
  localparam logic [10:0] V_ACT    = VA12[10:0];
  localparam logic [10:0] HS_BEG   = HS_BEG12[10:0];
  localparam logic [10:0] HS_END   = HS_END12[10:0];
  localparam logic [10:0] VS_BEG   = VS_BEG12[10:0];
  localparam logic [10:0] VS_END   = VS_END12[10:0];

  logic h_blank_reg, v_blank_reg, h_sync_reg, v_sync_reg;

  always_comb begin
    h_blank_reg = (hc >= H_ACT);
    v_blank_reg = (vc >= V_ACT);
    h_sync_reg  = (hc >= HS_BEG) && (hc <= HS_END);
    v_sync_reg  = (vc >= VS_BEG) && (vc <= VS_END);
  end

  always_ff @(posedge clk25m) begin
    if (rst) begin
      hc             <= '0;
      vc             <= '0;
      hsync          <= ~HSYNC_POL;
      vsync          <= ~VSYNC_POL;
      hblank         <= 1'b1;
      vblank         <= 1'b1;
      display_enable <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else if (ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
      end
      // Output stage decodes the pre-increment position, so it trails by one tick
      // and vsync naturally changes only at h=0.
      hsync          <= h_sync_reg ? HSYNC_POL : ~HSYNC_POL;
      vsync          <= v_sync_reg ? VSYNC_POL : ~VSYNC_POL;
      hblank         <= h_blank_reg || v_blank_reg;
      vblank         <= v_blank_reg;
      display_enable <= !(h_blank_reg || v_blank_reg);
      line_start     <= (hc == '0);
      frame_start    <= (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: three instances (default, small, small with
// inverted sync polarity) compared every cycle against a tick-count model.
module tb_video_timing_ctrl;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        de;
    logic        ls;
    logic        fs;
  } vt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  always #20 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned n      = 0;   // ce ticks since the last reset cycle
  int unsigned cyc    = 0;
  bit          checking = 1'b0;

  logic [10:0] d_hc, d_vc, s_hc, s_vc, p_hc, p_vc;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs;
  logic p_hs, p_vs, p_hb, p_vb, p_de, p_ls, p_fs;
  vt_t  d_o, s_o, p_o;

  assign d_o = {d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs};
  assign s_o = {s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs};
  assign p_o = {p_hc, p_vc, p_hs, p_vs, p_hb, p_vb, p_de, p_ls, p_fs};

  video_timing_ctrl u_def (
    .clk25m(clk), .rst(rst), .ce(ce), .hc(d_hc), .vc(d_vc),
    .hsync(d_hs), .vsync(d_vs), .hblank(d_hb), .vblank(d_vb),
    .display_enable(d_de), .line_start(d_ls), .frame_start(d_fs)
  );

  video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sml (
    .clk25m(clk), .rst(rst), .ce(ce), .hc(s_hc), .vc(s_vc),
    .hsync(s_hs), .vsync(s_vs), .hblank(s_hb), .vblank(s_vb),
    .display_enable(s_de), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_pol (
    .clk25m(clk), .rst(rst), .ce(ce), .hc(p_hc), .vc(p_vc),
    .hsync(p_hs), .vsync(p_vs), .hblank(p_hb), .vblank(p_vb),
    .display_enable(p_de), .line_start(p_ls), .frame_start(p_fs)
  );

  // After n ticks the counters sit at raster position n and the outputs
  // describe position n-1; n==0 is the reset state.
  function automatic vt_t model(input int unsigned nn,
                                input int unsigned ha, input int unsigned hf,
                                input int unsigned hw, input int unsigned hb,
                                input int unsigned va, input int unsigned vf,
                                input int unsigned vw, input int unsigned vb,
                                input bit hp, input bit vp);
    vt_t r;
    int unsigned ht, vt, p, h, v;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (nn == 0) begin
      r = {11'd0, 11'd0, ~hp, ~vp, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      return r;
    end
    r.hc = 11'(nn % ht);
    r.vc = 11'((nn / ht) % vt);
    p = nn - 1;
    h = p % ht;
    v = (p / ht) % vt;
    r.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
    r.vs = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
    r.vb = (v >= va);
    r.hb = (h >= ha) || (v >= va);
    r.de = !r.hb;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic vt_t exp_def(input int unsigned nn);
    return model(nn, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic vt_t exp_sml(input int unsigned nn);
    return model(nn, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
  endfunction
  function automatic vt_t exp_pol(input int unsigned nn);
    return model(nn, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d cyc=%0d)", nm, act, exp, n, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("def_outputs", 64'(d_o), 64'(exp_def(n)));
      chk("sml_outputs", 64'(s_o), 64'(exp_sml(n)));
      chk("pol_outputs", 64'(p_o), 64'(exp_pol(n)));
    end
  end

  task automatic cycle(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    if (r) n = 0;
    else if (c) n++;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int unsigned de_cnt, hs_lo, first_lo, last_lo, t;
    int unsigned d_rise[2], s_rise[2];
    int unsigned d_nr, s_nr;
    int unsigned m_de, m_ls, m_fs, m_vs;
    logic d_ls_q, s_ls_q;
    bit found;

    // Model pins against hand-computed defaults.
    chk("pin_hs_656", 64'(exp_def(657).hs), 64'(0));
    chk("pin_hs_655", 64'(exp_def(656).hs), 64'(1));
    chk("pin_hs_751", 64'(exp_def(752).hs), 64'(0));
    chk("pin_hs_752", 64'(exp_def(753).hs), 64'(1));
    chk("pin_vs_490", 64'(exp_def(490 * 800 + 1).vs), 64'(0));
    chk("pin_vs_489", 64'(exp_def(490 * 800).vs), 64'(1));
    chk("pin_vs_492", 64'(exp_def(492 * 800 + 1).vs), 64'(1));
    chk("pin_sml_wrap_fs", 64'(exp_sml(36).fs), 64'(1));
    chk("pin_sml_wrap_vb", 64'(exp_sml(36).vb), 64'(0));
    m_de = 0; m_vs = 0;
    for (int unsigned k = 1; k <= 420000; k++) begin
      vt_t e;
      e = exp_def(k);
      if (e.de) m_de++;
      if (!e.vs) m_vs++;
    end
    chk("pin_frame_de", 64'(m_de), 64'(307200));
    chk("pin_frame_vs", 64'(m_vs), 64'(1600));
    m_ls = 0; m_fs = 0;
    for (int unsigned k = 1; k <= 105; k++) begin
      if (exp_sml(k).ls) m_ls++;
      if (exp_sml(k).fs) m_fs++;
    end
    chk("pin_sml_ls", 64'(m_ls), 64'(15));
    chk("pin_sml_fs", 64'(m_fs), 64'(3));

    // Reset held 5 cycles with ce=1.
    @(negedge clk);
    cycle(1'b1, 1'b1);
    checking = 1'b1;
    repeat (4) cycle(1'b1, 1'b1);
    chk("rst_def", 64'(d_o), 64'({11'd0, 11'd0, 7'b1111000}));
    chk("rst_pol", 64'(p_o), 64'({11'd0, 11'd0, 7'b0011000}));

    // First tick after release.
    cycle(1'b0, 1'b1);
    chk("first_tick_fs", 64'(d_fs), 64'(1));
    chk("first_tick_de", 64'(d_de), 64'(1));
    chk("first_tick_hc", 64'(d_hc), 64'(1));

    // One default line: output ticks 0..799 are n = 1..800.
    de_cnt = 0; hs_lo = 0; first_lo = 9999; last_lo = 0;
    for (int unsigned k = 0; k < 800; k++) begin
      if (d_de) de_cnt++;
      if (!d_hs) begin
        hs_lo++;
        if (first_lo == 9999) first_lo = k;
        last_lo = k;
      end
      cycle(1'b0, 1'b1);
    end
    chk("line_de_count", 64'(de_cnt), 64'(640));
    chk("line_hs_count", 64'(hs_lo), 64'(96));
    chk("line_hs_first", 64'(first_lo), 64'(656));
    chk("line_hs_last", 64'(last_lo), 64'(751));
    chk("line_start_800", 64'(d_ls), 64'(1));

    // Alternate ce: periods double in clock cycles.
    d_nr = 0; s_nr = 0; d_ls_q = d_ls; s_ls_q = s_ls;
    d_rise = '{0, 0}; s_rise = '{0, 0};
    for (int unsigned i = 0; i < 4000 && d_nr < 2; i++) begin
      cycle(1'b0, (i % 2) == 0);
      if (d_ls && !d_ls_q && d_nr < 2) begin d_rise[d_nr] = cyc; d_nr++; end
      if (s_ls && !s_ls_q && s_nr < 2) begin s_rise[s_nr] = cyc; s_nr++; end
      d_ls_q = d_ls;
      s_ls_q = s_ls;
    end
    chk("ce_half_def_line_period", 64'(d_rise[1] - d_rise[0]), 64'(1600));
    chk("ce_half_sml_line_period", 64'(s_rise[1] - s_rise[0]), 64'(14));

    // Reset during both syncs on the small raster (counters (6,3), outputs (5,3)).
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      if (s_hc == 11'd6 && s_vc == 11'd3) found = 1'b1;
      else cycle(1'b0, 1'b1);
    end
    chk("mid_reset_reached", 64'(found), 64'(1));
    chk("mid_reset_syncs_on", 64'({s_hs, s_vs}), 64'(2'b00));
    cycle(1'b1, 1'b1);
    chk("mid_reset_syncs_off", 64'({s_hs, s_vs}), 64'(2'b11));
    chk("mid_reset_counters", 64'({s_hc, s_vc}), 64'(0));
    t = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1);
      t++;
      if (!s_vs) break;
    end
    chk("mid_reset_first_vsync", 64'(t), 64'(22));

    // Random ce with occasional resets.
    repeat (6000) cycle(($urandom % 500) == 0, ($urandom % 4) != 0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Raster sequencer for the HDMI output path. It generates the pixel/line counters and the registered HSYNC, VSYNC, blanking and display-enable signals consumed by the `hdmi` encoder and by pixel generators (example modules, framebuffer readers). The default parameters give 640x480@60 (800x525 total) on the 25 MHz pixel clock. A clock-enable input allows running from a faster clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`
- `clk25m`, in, 1, pixel clock. Single clock domain.
- `rst`, in, 1, synchronous reset, active-high
- `ce`, in, 1, pixel enable. All state advances only on `clk25m` edges with `ce`=1.
- `hc`, out, 11, horizontal counter, range 0..HT-1 with HT = H_ACTIVE+H_FP+H_SYNC+H_BP
- `vc`, out, 11, vertical counter, range 0..VT-1 with VT = V_ACTIVE+V_FP+V_SYNC+V_BP
- `hsync`, out, 1, horizontal sync at the parameterised polarity
- `vsync`, out, 1, vertical sync at the parameterised polarity
- `hblank`, out, 1, 1 when outside the active area, horizontally or vertically
- `vblank`, out, 1, 1 when vertical position is outside the active lines
- `display_enable`, out, 1, equals ~`hblank`
- `line_start`, out, 1, one-tick pulse at pixel 0 of every line
- `frame_start`, out, 1, one-tick pulse at pixel 0 of line 0

## Operation
- **Counters**
  - On `ce`: `hc` increments. When `hc`==HT-1 it wraps to 0 and `vc` increments.
  - When `vc`==VT-1 and `hc`==HT-1, both wrap to 0 on the same tick.
  - `ce`=0 holds every register, including all outputs.
- **Output stage** (registered one `ce` tick behind the counters; the stage is "video" state for `hc`/`vc` = (h,v))
  - h-blank region: h >= H_ACTIVE
  - v-blank region: v >= V_ACTIVE
  - hsync asserted: H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1
  - vsync asserted: V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1, over whole lines, with changes aligned to h=0
  - `hblank` = h-blank OR v-blank
  - `line_start` = (h==0)
  - `frame_start` = (h==0 AND v==0)
- **Pixel path contract.** A pixel generator may use `hc`/`vc` to address a 1-cycle-latency memory. Its registered data then lines up with `display_enable`/syncs.
- **Reset**
  - Counters: `hc`=0, `vc`=0.
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL.
  - `hblank`=1, `vblank`=1, `display_enable`=0.
  - `line_start`=0, `frame_start`=0.
  - Reset dominates `ce`.
  - Reset mid-frame returns immediately to this state. The next frame restarts cleanly with no partial sync pulse.
- **Width rule.** HT and VT must be ≤ 2048. Parameter sums are computed at 12 bits and compared at 11 bits.

## Timing
- First tick with `ce`=1 after `rst` falls:
  - counters go 0→1.
  - The output stage loads state for (0,0): `display_enable`=1, `line_start`=1, `frame_start`=1.
- **Latency.** Outputs lag counters by exactly 1 `ce` tick. Latency is measured in `ce` ticks, not `clk25m` cycles.
- **Periods.**
  - `line_start` period = HT ticks.
  - `frame_start` period = HT×VT ticks.
  - `hsync` width = H_SYNC ticks per line, on every line including v-blank.
  - `vsync` width = V_SYNC×HT ticks.
- **Boundary conditions.**
  - At the simultaneous h/v wrap, `frame_start` and `line_start` assert on the same tick.
  - `vblank` deasserts on that same tick.
- **Defaults.**
  - `hsync` low for output-stage h = 656..751.
  - `vsync` low for v = 490..491.
  - 307200 `display_enable` ticks per frame.

## Test plan
- **Reset values.** Hold `rst` 5 cycles with `ce`=1 → all outputs at the reset values listed above, `hc`=`vc`=0. Release → next tick `frame_start`=1, `display_enable`=1.
- **One line, defaults.** Run 800 ticks with `ce`=1.
  - → `display_enable` high for ticks 0..639.
  - → `hsync` low for ticks 656..751.
  - → `line_start` again at tick 800.
- **Full frame.** Run 420000 ticks.
  - → exactly one `frame_start`, 525 `line_start`.
  - → 307200 `display_enable` ticks.
  - → `vsync` low for 1600 ticks, starting with line 490.
- **Clock enable.** Drive `ce` on alternate cycles → every period doubles in `clk25m` cycles. Output values are unchanged and all outputs are stable while `ce`=0.
- **Reset mid-operation.** Assert `rst` at `hc`=700, `vc`=491, during both hsync and vsync.
  - → next cycle both syncs are inactive and counters are 0.
  - → after release, the first `vsync` assertion occurs 490 lines later.
- **Small parameters.** H=4/1/1/1, V=2/1/1/1 (HT=7, VT=5) → exhaustive compare of every output against a reference model over 3 frames, including the wrap tick.
